// File: rtl/down_counter_timer_if.sv
// Handshake bundle for down_counter_timer: control/load inputs and count/status outputs.
interface down_counter_timer_if #(
  parameter int unsigned WIDTH = 30
) ();
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             start;
  logic             pause;
  logic             dec;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             expired;

  modport master (
    output load, load_val, start, pause, dec,
    input  count, busy, done, expired
  );

  modport slave (
    input  load, load_val, start, pause, dec,
    output count, busy, done, expired
  );
endinterface

// File: rtl/down_counter_timer.sv
// Programmable down-counter/timer with done pulse and sticky expired state.
// Optional periodic mode: define AUTO_RELOAD_EN to reload and keep running on expiry.
module down_counter_timer #(
  parameter int unsigned WIDTH = 30
) (
  input logic              clk,
  input logic              clr_n,
  down_counter_timer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StExpired} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (bus.load) begin
      count_d  = bus.load_val;
      reload_d = bus.load_val;
      state_d  = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (count_q != '0) begin
              state_d = StRun;
            end else begin
              state_d = StExpired;
              done_d  = 1'b1;
            end
          end
        end
        StRun: begin
          if (bus.pause) begin
            state_d = StPaused;
          end else if (bus.dec && (count_q != '0)) begin
            if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = StExpired;
`endif
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        StPaused: begin
          // start takes precedence over a simultaneous pause here
          if (bus.start) begin
            state_d = StRun;
          end
        end
        StExpired: begin
          if (bus.start) begin
            if (reload_q != '0) begin
              count_d = reload_q;
              state_d = StRun;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign bus.count   = count_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q == StRun) || (state_q == StPaused);
  assign bus.expired = (state_q == StExpired);

endmodule
